// File: rtl/conbus_rr.sv
`default_nettype none
// ============================================================================
// Module      : conbus_rr
// Description : Shared-bus Wishbone interconnect with a round-robin master
//               arbiter, address-prefix slave decode and bus-error generation
//               for unmapped accesses and no-ack timeouts.
//
// Ports
//   sys_clk, sys_rst           : clock, asynchronous active-high reset
//   m_adr_i/m_dat_i/m_cti_i/   : packed per-master request buses (master i at
//   m_sel_i/m_we_i/m_cyc_i/      slice i)
//   m_stb_i
//   m_dat_o                    : read data returned to the granted master
//   m_ack_o, m_err_o           : per-master ack and bus-error
//   s_adr_o/s_dat_o/s_cti_o/   : granted master's request, shared by slaves
//   s_sel_o/s_we_o/s_cyc_o
//   s_stb_o                    : per-slave strobe
//   s_dat_i, s_ack_i           : packed slave read data and acks
//   gnt_o                      : one-hot current grant (zero when idle)
//   slave_selected             : one-hot decoded slave (zero if unmapped/idle)
//
// Revision    : 1.0 - initial release
// ============================================================================
module conbus_rr #(
  parameter int                        N_M      = 6,
  parameter int                        N_S      = 6,
  parameter int                        S_ADDR_W = 4,
  parameter logic [N_S*S_ADDR_W-1:0]   S_ADDR   = {4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0},
  parameter int                        TIMEOUT  = 255
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  // master side
  input  logic [N_M*32-1:0]   m_adr_i,
  input  logic [N_M*32-1:0]   m_dat_i,
  input  logic [N_M*3-1:0]    m_cti_i,
  input  logic [N_M*4-1:0]    m_sel_i,
  input  logic [N_M-1:0]      m_we_i,
  input  logic [N_M-1:0]      m_cyc_i,
  input  logic [N_M-1:0]      m_stb_i,
  output logic [31:0]         m_dat_o,
  output logic [N_M-1:0]      m_ack_o,
  output logic [N_M-1:0]      m_err_o,
  // slave side
  output logic [31:0]         s_adr_o,
  output logic [31:0]         s_dat_o,
  output logic [2:0]          s_cti_o,
  output logic [3:0]          s_sel_o,
  output logic                s_we_o,
  output logic                s_cyc_o,
  output logic [N_S-1:0]      s_stb_o,
  input  logic [N_S*32-1:0]   s_dat_i,
  input  logic [N_S-1:0]      s_ack_i,
  // status
  output logic [N_M-1:0]      gnt_o,
  output logic [N_S-1:0]      slave_selected
);

  localparam int c_MW = (N_M > 1) ? $clog2(N_M) : 1;
  localparam int c_CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen during the last no-ack cycle before expiry.
  localparam logic [c_CW-1:0] c_TO_LAST = (TIMEOUT > 0) ? c_CW'(TIMEOUT - 1) : '0;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic             r_valid;
  logic [c_MW-1:0]  r_gnt;
  logic [c_MW-1:0]  r_last;
  logic [c_CW-1:0]  r_cnt;
  logic             r_err;

  // --------------------------------------------------------------------------
  // Round-robin search: first requester after the last-served master.
  // --------------------------------------------------------------------------
  logic             w_req_any;
  logic [c_MW-1:0]  w_next;

  always_comb begin
    int idx;
    w_req_any = 1'b0;
    w_next    = '0;
    idx       = 0;
    for (int k = 1; k <= N_M; k++) begin
      idx = (int'(r_last) + k) % N_M;
      if (!w_req_any && m_cyc_i[idx]) begin
        w_req_any = 1'b1;
        w_next    = c_MW'(idx);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Granted-master multiplexer; everything reads as zero while idle.
  // --------------------------------------------------------------------------
  logic [31:0]      w_adr;
  logic [31:0]      w_dat;
  logic [2:0]       w_cti;
  logic [3:0]       w_sel;
  logic             w_we;
  logic             w_cyc_g;
  logic             w_stb_g;
  logic [N_M-1:0]   w_gnt_vec;

  always_comb begin
    w_adr     = '0;
    w_dat     = '0;
    w_cti     = '0;
    w_sel     = '0;
    w_we      = 1'b0;
    w_cyc_g   = 1'b0;
    w_stb_g   = 1'b0;
    w_gnt_vec = '0;
    for (int i = 0; i < N_M; i++) begin
      if (r_valid && (r_gnt == c_MW'(i))) begin
        w_adr        = m_adr_i[i*32 +: 32];
        w_dat        = m_dat_i[i*32 +: 32];
        w_cti        = m_cti_i[i*3 +: 3];
        w_sel        = m_sel_i[i*4 +: 4];
        w_we         = m_we_i[i];
        w_cyc_g      = m_cyc_i[i];
        w_stb_g      = m_stb_i[i];
        w_gnt_vec[i] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Slave decode on the top address bits; lowest index wins on overlap.
  // --------------------------------------------------------------------------
  logic [N_S-1:0]   w_match;
  logic [N_S-1:0]   w_slv;
  logic             w_mapped;

  for (genvar k = 0; k < N_S; k++) begin : g_match
    assign w_match[k] = (w_adr[31 -: S_ADDR_W] == S_ADDR[k*S_ADDR_W +: S_ADDR_W]);
  end

  always_comb begin
    logic found;
    found = 1'b0;
    w_slv = '0;
    for (int k = 0; k < N_S; k++) begin
      // The idle address of zero could match a slave, so decode needs a grant.
      if (r_valid && !found && w_match[k]) begin
        found    = 1'b1;
        w_slv[k] = 1'b1;
      end
    end
  end

  assign w_mapped = |w_slv;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic             w_stb_act;
  logic             w_ack;

  // Active strobe from the granted master (already zero while idle).
  assign w_stb_act = w_cyc_g & w_stb_g;
  // An error cycle suppresses the transfer, so a late slave ack is dropped.
  assign w_ack     = ~r_err & |(s_ack_i & w_slv);

  always_comb begin
    m_dat_o = '0;
    for (int k = 0; k < N_S; k++) begin
      if (w_slv[k]) begin
        m_dat_o = s_dat_i[k*32 +: 32];
      end
    end
  end

  assign m_ack_o        = w_ack ? w_gnt_vec : '0;
  assign m_err_o        = r_err ? w_gnt_vec : '0;
  assign s_stb_o        = (w_stb_act && !r_err) ? w_slv : '0;
  assign s_adr_o        = w_adr;
  assign s_dat_o        = w_dat;
  assign s_cti_o        = w_cti;
  assign s_sel_o        = w_sel;
  assign s_we_o         = w_we;
  assign s_cyc_o        = w_cyc_g;
  assign gnt_o          = w_gnt_vec;
  assign slave_selected = w_slv;

  // --------------------------------------------------------------------------
  // Sequential state: arbiter, error pulse, timeout counter
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_valid <= 1'b0;
      r_gnt   <= '0;
      r_last  <= c_MW'(N_M - 1);   // master 0 searched first after reset
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      // Arbiter: hold while cyc stays high, then spend one idle cycle in
      // which the next requester is picked.
      if (r_valid) begin
        if (!w_cyc_g) begin
          r_valid <= 1'b0;
          r_last  <= r_gnt;
        end
      end else if (w_req_any) begin
        r_valid <= 1'b1;
        r_gnt   <= w_next;
      end

      // Error flag lasts exactly one cycle; it is never re-armed while set,
      // and it clears together with a dropped grant.
      r_err <= 1'b0;
      if (!r_err && w_stb_act) begin
        if (!w_mapped) begin
          r_err <= 1'b1;
        end else if ((TIMEOUT > 0) && !w_ack && (r_cnt == c_TO_LAST)) begin
          r_err <= 1'b1;
        end
      end

      // Timeout counter: counts consecutive no-ack strobe cycles to a
      // mapped slave; an ack in the expiry cycle wins over the timeout.
      if ((TIMEOUT == 0) || r_err || !w_stb_act || !w_mapped || w_ack) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conbus_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_conbus_rr
// Description : Scoreboard bench for conbus_rr. Directed scenarios push the
//               expected grant/ack/error events (with their cycle numbers)
//               into a queue; a negedge monitor pops and compares whenever
//               the DUT shows a new grant, an ack or an error.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conbus_rr;

  localparam int N_M = 6;
  localparam int N_S = 6;
  localparam int K_GNT = 0;
  localparam int K_ACK = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [5:0]  vec;
    logic [31:0] dat;
    logic [5:0]  stb;
    logic [5:0]  sel;
  } exp_t;

  exp_t sb[$];

  logic                sys_clk;
  logic                sys_rst;
  logic [N_M*32-1:0]   m_adr_i;
  logic [N_M*32-1:0]   m_dat_i;
  logic [N_M*3-1:0]    m_cti_i;
  logic [N_M*4-1:0]    m_sel_i;
  logic [N_M-1:0]      m_we_i;
  logic [N_M-1:0]      m_cyc_i;
  logic [N_M-1:0]      m_stb_i;
  logic [31:0]         m_dat_o;
  logic [N_M-1:0]      m_ack_o;
  logic [N_M-1:0]      m_err_o;
  logic [31:0]         s_adr_o;
  logic [31:0]         s_dat_o;
  logic [2:0]          s_cti_o;
  logic [3:0]          s_sel_o;
  logic                s_we_o;
  logic                s_cyc_o;
  logic [N_S-1:0]      s_stb_o;
  logic [N_S*32-1:0]   s_dat_i;
  logic [N_S-1:0]      s_ack_i;
  logic [N_M-1:0]      gnt_o;
  logic [N_S-1:0]      slave_selected;

  // stimulus state
  logic [5:0]  cyc_v;
  logic [5:0]  stb_v;
  logic [5:0]  ack_mask;
  logic [31:0] adr [N_M];

  int cyc_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;

  conbus_rr #(.TIMEOUT(4)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .m_adr_i        (m_adr_i),
    .m_dat_i        (m_dat_i),
    .m_cti_i        (m_cti_i),
    .m_sel_i        (m_sel_i),
    .m_we_i         (m_we_i),
    .m_cyc_i        (m_cyc_i),
    .m_stb_i        (m_stb_i),
    .m_dat_o        (m_dat_o),
    .m_ack_o        (m_ack_o),
    .m_err_o        (m_err_o),
    .s_adr_o        (s_adr_o),
    .s_dat_o        (s_dat_o),
    .s_cti_o        (s_cti_o),
    .s_sel_o        (s_sel_o),
    .s_we_o         (s_we_o),
    .s_cyc_o        (s_cyc_o),
    .s_stb_o        (s_stb_o),
    .s_dat_i        (s_dat_i),
    .s_ack_i        (s_ack_i),
    .gnt_o          (gnt_o),
    .slave_selected (slave_selected)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] sdat(int k);
    if (k == 3) return 32'hDEAD_BEEF;
    return 32'(32'h1111_1111 * (k + 1));
  endfunction

  // Zero-wait slaves: a slave acks in the strobe cycle when its mask bit is set.
  always_comb begin
    m_cyc_i = cyc_v;
    m_stb_i = stb_v;
    m_we_i  = '0;
    s_ack_i = s_stb_o & ack_mask;
    for (int i = 0; i < N_M; i++) begin
      m_adr_i[i*32 +: 32] = adr[i];
      m_dat_i[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);
      m_cti_i[i*3 +: 3]   = 3'b000;
      m_sel_i[i*4 +: 4]   = 4'hF;
    end
    for (int k = 0; k < N_S; k++) s_dat_i[k*32 +: 32] = sdat(k);
  end

  // ---------------------------------------------------------------- checking
  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc_cnt);
  endtask

  task automatic observe(int kind, logic [5:0] vec, logic [31:0] dat,
                         logic [5:0] stb, logic [5:0] sel);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL unexpected_event: kind %0d vec %b at cycle %0d, none expected",
               kind, vec, cyc_cnt);
    end else begin
      e = sb.pop_front();
      if (e.kind == kind && e.cyc == cyc_cnt && e.vec == vec && e.dat == dat &&
          e.stb == stb && e.sel == sel) begin
        n_pass++;
      end else begin
        $display("FAIL event: got kind %0d cyc %0d vec %b dat %h stb %b sel %b, expected kind %0d cyc %0d vec %b dat %h stb %b sel %b",
                 kind, cyc_cnt, vec, dat, stb, sel,
                 e.kind, e.cyc, e.vec, e.dat, e.stb, e.sel);
      end
    end
  endtask

  logic [5:0] prev_gnt = '0;
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      prev_gnt <= '0;
    end else begin
      if (gnt_o != '0 && gnt_o != prev_gnt) observe(K_GNT, gnt_o, '0, '0, '0);
      if (m_ack_o != '0) observe(K_ACK, m_ack_o, m_dat_o, s_stb_o, slave_selected);
      if (m_err_o != '0) observe(K_ERR, m_err_o, m_dat_o, s_stb_o, slave_selected);
      prev_gnt <= gnt_o;
    end
  end

  function automatic void exp_gnt(int c, logic [5:0] v);
    sb.push_back('{K_GNT, c, v, 32'h0, 6'h0, 6'h0});
  endfunction
  function automatic void exp_ack(int c, logic [5:0] v, logic [31:0] d,
                                  logic [5:0] stb, logic [5:0] sel);
    sb.push_back('{K_ACK, c, v, d, stb, sel});
  endfunction
  function automatic void exp_err(int c, logic [5:0] v, logic [31:0] d,
                                  logic [5:0] stb, logic [5:0] sel);
    sb.push_back('{K_ERR, c, v, d, stb, sel});
  endfunction

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst  = 1'b1;
    cyc_v    = '0;
    stb_v    = '0;
    ack_mask = '1;
    tick();
    tick();
    check("rst_outputs", 64'({gnt_o, m_ack_o, m_err_o, s_stb_o, s_cyc_o, slave_selected}), 64'h0);
    sys_rst = 1'b0;
  endtask

  task automatic wait_ack(int m);
    int n;
    n = 0;
    tick();
    while (!m_ack_o[m] && n < 10) begin
      tick();
      n++;
    end
    if (!m_ack_o[m]) begin
      n_checks++;
      $display("FAIL wait_ack_m%0d: got no ack within bound, required ack", m);
    end
  endtask

  int c;
  int order [6] = '{1, 2, 3, 4, 5, 1};

  initial begin
    sys_rst  = 1'b1;
    cyc_v    = '0;
    stb_v    = '0;
    ack_mask = '1;
    for (int i = 0; i < N_M; i++) adr[i] = {i[3:0], 28'h0};

    // m0 and m3 request together: m0 first, one idle cycle, then m3.
    do_reset();
    c = cyc_cnt;
    cyc_v = 6'b001001;
    exp_gnt(c + 1, 6'b000001);
    tick(); tick();
    cyc_v[0] = 1'b0;
    exp_gnt(c + 4, 6'b001000);
    tick();
    check("handover_idle", 64'(gnt_o), 64'h0);
    tick(); tick();
    cyc_v[3] = 1'b0;
    tick(); tick();

    // Round robin among m1..m5, one acked access per tenure.
    do_reset();
    for (int i = 0; i < N_M; i++) adr[i] = {i[3:0], 28'h0};
    c = cyc_cnt;
    cyc_v = 6'b111110;
    stb_v = 6'b111110;
    for (int k = 0; k < 6; k++) begin
      exp_gnt(c + 1 + 3 * k, 6'(1 << order[k]));
      exp_ack(c + 1 + 3 * k, 6'(1 << order[k]), sdat(order[k]),
              6'(1 << order[k]), 6'(1 << order[k]));
    end
    for (int k = 0; k < 6; k++) begin
      wait_ack(order[k]);
      tick();
      cyc_v[order[k]] = 1'b0;
      stb_v[order[k]] = 1'b0;
      tick();
      if (k < 5) begin
        cyc_v[order[k]] = 1'b1;
        stb_v[order[k]] = 1'b1;
      end
    end
    tick();

    // m2 reads slave 3.
    do_reset();
    adr[2] = 32'h3000_0010;
    c = cyc_cnt;
    cyc_v[2] = 1'b1;
    stb_v[2] = 1'b1;
    exp_gnt(c + 1, 6'b000100);
    exp_ack(c + 1, 6'b000100, 32'hDEAD_BEEF, 6'b001000, 6'b001000);
    wait_ack(2);
    check("s3_adr_out", 64'(s_adr_o), 64'h3000_0010);
    tick();
    cyc_v = '0;
    stb_v = '0;
    tick();

    // m0 strobes an unmapped address.
    do_reset();
    adr[0] = 32'hF000_0000;
    c = cyc_cnt;
    cyc_v[0] = 1'b1;
    stb_v[0] = 1'b1;
    exp_gnt(c + 1, 6'b000001);
    exp_err(c + 2, 6'b000001, 32'h0, 6'h0, 6'h0);
    tick();
    check("unmapped_stb", 64'(s_stb_o), 64'h0);
    tick();
    cyc_v = '0;
    stb_v = '0;
    tick(); tick();

    // Timeout: slave 1 never acks; error after the 4th no-ack cycle.
    do_reset();
    adr[1] = 32'h1000_0000;
    ack_mask = 6'b111101;
    c = cyc_cnt;
    cyc_v[1] = 1'b1;
    stb_v[1] = 1'b1;
    exp_gnt(c + 1, 6'b000010);
    exp_err(c + 5, 6'b000010, sdat(1), 6'h0, 6'b000010);
    tick(); tick(); tick(); tick();
    check("to_stb_live", 64'(s_stb_o), 64'b000010);
    tick();
    cyc_v = '0;
    stb_v = '0;
    tick();
    check("err_cleared", 64'(m_err_o), 64'h0);
    tick();

    // Timeout race: ack arrives in the expiry cycle and wins.
    do_reset();
    adr[1] = 32'h1000_0000;
    ack_mask = 6'b111101;
    c = cyc_cnt;
    cyc_v[1] = 1'b1;
    stb_v[1] = 1'b1;
    exp_gnt(c + 1, 6'b000010);
    exp_ack(c + 4, 6'b000010, sdat(1), 6'b000010, 6'b000010);
    tick(); tick(); tick(); tick();
    ack_mask = '1;
    tick();
    cyc_v = '0;
    stb_v = '0;
    check("race_no_err", 64'(m_err_o), 64'h0);
    tick(); tick();

    // Reset mid-burst, then m4 requests across the release.
    do_reset();
    adr[2] = 32'h2000_0000;
    c = cyc_cnt;
    cyc_v[2] = 1'b1;
    stb_v[2] = 1'b1;
    exp_gnt(c + 1, 6'b000100);
    exp_ack(c + 1, 6'b000100, sdat(2), 6'b000100, 6'b000100);
    exp_ack(c + 2, 6'b000100, sdat(2), 6'b000100, 6'b000100);
    tick(); tick(); tick();
    sys_rst = 1'b1;
    #1;
    check("midrst_gnt", 64'(gnt_o), 64'h0);
    check("midrst_stb", 64'(s_stb_o), 64'h0);
    check("midrst_ack", 64'(m_ack_o), 64'h0);
    check("midrst_cyc", 64'(s_cyc_o), 64'h0);
    check("midrst_dat", 64'(m_dat_o), 64'h0);
    cyc_v = 6'b010000;
    stb_v = '0;
    tick(); tick();
    check("rst_hold_gnt", 64'(gnt_o), 64'h0);
    sys_rst = 1'b0;
    exp_gnt(cyc_cnt + 1, 6'b010000);
    tick();
    tick();
    cyc_v = '0;
    tick(); tick(); tick();

    check("scoreboard_drain", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/conbus_rr.md
CONBUS_RR -- requirements
Module: conbus_rr

Interface
REQ-001 SHALL have parameter N_M, default 6, number of Wishbone masters (1..8).
REQ-002 SHALL have parameter N_S, default 6, number of slaves (1..8).
REQ-003 SHALL have parameter S_ADDR_W, default 4, number of address MSBs used for slave decode.
REQ-004 SHALL have parameter S_ADDR, default {4'h5,4'h4,4'h3,4'h2,4'h1,4'h0}, packed N_S*S_ADDR_W slave base prefixes, with slave k at slice k.
REQ-005 SHALL have parameter TIMEOUT, default 255, the number of no-ack strobe cycles before a bus error; 0 disables the timeout.
REQ-006 SHALL use one clock; reset is asynchronous and active-high, with ports named sys_clk and sys_rst.
REQ-007 sys_clk  in  1  system clock.
REQ-008 sys_rst  in  1  asynchronous active-high reset.
REQ-009 m_adr_i  in  N_M*32  master addresses, master i at slice i.
REQ-010 m_dat_i  in  N_M*32  master write data.
REQ-011 m_cti_i  in  N_M*3  master cycle type.
REQ-012 m_sel_i  in  N_M*4  master byte selects.
REQ-013 m_we_i / m_cyc_i / m_stb_i  in  N_M each  master write enable, cycle and strobe.
REQ-014 m_dat_o  out  32  read data, shared by all masters.
REQ-015 m_ack_o / m_err_o  out  N_M each  per-master ack and bus error.
REQ-016 s_adr_o / s_dat_o  out  32 each  granted master's address and write data, shared by all slaves.
REQ-017 s_cti_o / s_sel_o / s_we_o / s_cyc_o  out  3/4/1/1  granted master's controls.
REQ-018 s_stb_o  out  N_S  per-slave strobe.
REQ-019 s_dat_i  in  N_S*32  slave read data.
REQ-020 s_ack_i  in  N_S  slave acks.
REQ-021 gnt_o  out  N_M  one-hot current grant, all zero when idle.
REQ-022 slave_selected  out  N_S  one-hot decoded slave, all zero when unmapped or idle.

Function
REQ-023 Arbiter SHALL be round-robin; state = grant valid bit plus grant index g plus last-served index l.
- IDLE: valid=0.
- Transition: registered grant to the first i with m_cyc_i[i]=1, searching (l+1)..(l+N_M) mod N_M.
- Effective: the cycle after the request is seen.
REQ-024 Grant SHALL be held while m_cyc_i[g]=1.
- On m_cyc_i[g]=0: next cycle valid=0 and l=g; re-arbitration occurs in that idle cycle.
- Each handover therefore costs exactly one idle cycle.
REQ-025 When valid=1, s_adr_o, s_dat_o, s_cti_o, s_sel_o and s_we_o SHALL carry master g's signals; s_cyc_o SHALL equal m_cyc_i[g]; all of these SHALL be zero when idle.
REQ-026 Decode: slave k SHALL match when s_adr_o[31:32-S_ADDR_W]==S_ADDR[k]; lowest k wins on multiple matches; no match = unmapped.
REQ-027 s_stb_o[k] SHALL equal valid & m_cyc_i[g] & m_stb_i[g] & match[k] & ~err_q.
REQ-028 m_dat_o SHALL carry s_dat_i of the selected slave, or 0 when unmapped or idle.
REQ-029 m_ack_o[g] SHALL be combinational: |(s_ack_i & slave_selected); all other masters' ack bits SHALL be 0; acks from unselected slaves SHALL be ignored.
REQ-030 Unmapped strobe SHALL register err_q=1, so m_err_o[g]=1 for exactly one cycle, in the cycle after the strobe is seen.
REQ-031 Timeout counter SHALL have width $clog2(TIMEOUT+1).
- Increments each cycle with an active strobe to a mapped slave and no ack.
- Clears on ack, on err_q, on stb low, or when idle.
- On reaching TIMEOUT, registers err_q=1, giving a one-cycle m_err_o[g].
REQ-032 During an err_q cycle, s_stb_o SHALL be all zero and m_ack_o SHALL be all zero; the following cycle is a fresh attempt if stb is still high.
REQ-033 Simultaneous ack and timeout expiry: ack SHALL win; no err is raised and the counter clears.
REQ-034 If the granted master drops cyc while err_q=1, err_q SHALL still clear the next cycle; it SHALL never carry over to a new grant.
REQ-035 TIMEOUT=0: the counter SHALL remain 0 and only unmapped accesses raise errors.

Reset
REQ-036 While sys_rst=1, asynchronously: valid=0, l=N_M-1 (master 0 has first priority), counter=0, err_q=0.
- All strobes, acks, errs, gnt_o and s_cyc_o SHALL be 0 immediately.
- Holds even when reset asserts mid-transfer; the first grant comes no earlier than one cycle after reset release.

Verification
REQ-037 m0 and m3 raise cyc in the same cycle, reset state -> gnt_o=000001 next cycle; after m0 drops cyc, one idle cycle, then gnt_o=001000.
REQ-038 m1..m5 hold cyc continuously, each dropping cyc after one acked access -> grant order 1,2,3,4,5,1, each handover separated by one idle cycle.
REQ-039 m2 reads 0x3000_0010, s3 acks with data 0xDEADBEEF -> s_stb_o=001000, m_ack_o[2]=1, m_dat_o=0xDEADBEEF, slave_selected=001000.
REQ-040 m0 strobes 0xF000_0000 (unmapped) -> next cycle m_err_o[0]=1 for one cycle, no s_stb_o, m_dat_o=0.
REQ-041 TIMEOUT=4, slave 1 never acks -> m_err_o pulses one cycle after the 4th no-ack cycle and s_stb_o[1]=0 in that cycle; a second run with ack arriving in the expiry cycle -> ack only, no err.
REQ-042 sys_rst asserted mid-burst -> all outputs 0 in the same cycle; after release with m4 requesting, gnt_o=010000 one cycle later.
